// File: rtl/mdu_hilo_if.sv
// Command/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply / restoring divide unit owning the MIPS HI/LO registers.
// Signed ops run on magnitudes and are sign-corrected in the FIN cycle.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q, neg_res_q, neg_rem_q, div0_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 signed_op, op_div;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign abs_a     = (signed_op && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign abs_b     = (signed_op && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  // acc_q holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Divide-by-zero forces an all-ones quotient; the remainder path already reproduces rs_val.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (div0_q)         quot_fix = {WIDTH{1'b1}};
    else if (neg_res_q) quot_fix = -acc_q[WIDTH-1:0];
    else                quot_fix = acc_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q   <= RUN;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                is_div_q  <= op_div;
                opb_q     <= abs_b;
                acc_q     <= {{WIDTH{1'b0}}, abs_a};
                neg_res_q <= signed_op && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                neg_rem_q <= signed_op && bus.rs_val[WIDTH-1];
                div0_q    <= op_div && (bus.rt_val == '0);
              end
              OP_MTHI: hi_q <= bus.rs_val;
              OP_MTLO: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
        end
        FIN: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic reference model checked every cycle plus literal expectations.
module tb_mdu_hilo;
  localparam int W = 32;

  logic clk, rst;
  int   errors = 0;
  int   checks = 0;
  int   n;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one mult/div command, returned as {hi, lo}.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    logic [31:0]     q, r;
    case (o)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = a / b; r = a % b;
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_cnt;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        end
      end else if (bus.start) begin
        if (bus.op <= 3'd3) begin
          m_cnt  <= W + 1;
          m_busy <= 1'b1;
          m_pend <= model_res(bus.op, bus.rs_val, bus.rt_val);
        end else if (bus.op == 3'd4) m_hi <= bus.rs_val;
        else if (bus.op == 3'd5) m_lo <= bus.rs_val;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("hi",   bus.hi,   m_hi);
      check("lo",   bus.lo,   m_lo);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
    check({name, "_hi"}, bus.hi, h);
    check({name, "_lo"}, bus.lo, l);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs_val = '0; bus.rt_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    expect_hilo("rst", 32'h0, 32'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_latency", n, 33);
    check("multu_done", bus.done, 1'b1);
    expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("done_pulse_width", bus.done, 1'b0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, n);
    expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, n);
    expect_hilo("mult_min", 32'h4000_0000, 32'h0);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2, n);
    expect_hilo("divu", 32'd1, 32'd3);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
    expect_hilo("div_negdiv", 32'd1, 32'hFFFF_FFFD);
    run_op(3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, n);
    expect_hilo("div_bothneg", 32'hFFFF_FFFE, 32'd2);

    run_op(3'd2, 32'h0000_1234, 32'd0, n);
    check("div0_latency", n, 33);
    expect_hilo("div0", 32'h0000_1234, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, n);
    expect_hilo("div0_neg", 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    expect_hilo("div_ovf", 32'h0, 32'h8000_0000);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi_lo_kept", bus.lo, 32'h8000_0000);
    bus.op = 3'd5; bus.rs_val = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    expect_hilo("mtlo", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    check("mt_busy", bus.busy, 1'b0);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.rs_val = 32'd1;
    @(negedge clk);
    bus.op = 3'd2; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    expect_hilo("busy_hold", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    n = 0;
    while (bus.busy && n < 200) begin n++; @(negedge clk); end
    check("ignored_done", bus.done, 1'b1);
    expect_hilo("ignored", 32'h0, 32'd12);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.rs_val = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    expect_hilo("noop", 32'h0, 32'd12);
    check("noop_busy", bus.busy, 1'b0);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    expect_hilo("abort", 32'h0, 32'h0);
    @(negedge clk);
    check("abort_no_done", bus.done, 1'b0);

    run_op(3'd1, 32'd2, 32'd3, n);
    check("post_abort_latency", n, 33);
    expect_hilo("post_abort", 32'h0, 32'd6);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
